core_test_monitor: RTL and testbench

//  Synthesizable run controller and monitor that sits between the bench and the rv32im core.
//  - Stretches bench reset into a parametrised core reset.
//  - Counts cycles and retired instructions.
//  - Tracks one architectural register via the register-file write port.
//  - Detects test completion: store to a halt address, or timeout.
//  - Reports a latched done/pass/timeout verdict in place of fixed-delay $finish.

---
 rtl/core_test_monitor.sv | 121 ++++++++++++
 tb/tb_core_test_monitor.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/core_test_monitor.sv
// ============================================================================
// core_test_monitor: stretches bench reset into a core reset, counts cycles
// and retired instructions, mirrors one register and latches the test verdict.
// Revision 1.0
// ============================================================================
`default_nettype none

module core_test_monitor #(
  parameter int              XLEN           = 32,
  parameter int              CNT_W          = 32,
  parameter int              RESET_CYCLES   = 4,
  parameter int              TIMEOUT_CYCLES = 1000,
  parameter int              CHECK_REG      = 5,
  parameter logic [XLEN-1:0] HALT_ADDR      = 32'h0000_0FFC,
  parameter logic [XLEN-1:0] PASS_VALUE     = 32'h0000_0001
) (
  input  logic             clk,
  input  logic             rst,
  output logic             core_rst_o,
  input  logic             retire_i,
  input  logic             rf_we_i,
  input  logic [4:0]       rf_waddr_i,
  input  logic [XLEN-1:0]  rf_wdata_i,
  input  logic             dmem_we_i,
  input  logic [XLEN-1:0]  dmem_addr_i,
  input  logic [XLEN-1:0]  dmem_wdata_i,
  output logic [CNT_W-1:0] cycle_count_o,
  output logic [CNT_W-1:0] instret_count_o,
  output logic [XLEN-1:0]  check_value_o,
  output logic [XLEN-1:0]  halt_data_o,
  output logic [1:0]       state_o,
  output logic             done_o,
  output logic             pass_o,
  output logic             timeout_o
);

  localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RC_W-1:0]  C_RST_LAST = RC_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]       C_CHK_IDX  = 5'(CHECK_REG);

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  state_t           state_q;
  logic [RC_W-1:0]  rst_cnt_q;
  logic             core_rst_q;
  logic [CNT_W-1:0] cycle_q, instret_q;
  logic [CNT_W-1:0] cycle_d, instret_d;
  logic [XLEN-1:0]  check_q, halt_data_q;
  logic             done_q, pass_q, timeout_q;

  logic w_halt, w_timeout, w_rf_hit;

  assign cycle_d   = (&cycle_q) ? cycle_q : cycle_q + CNT_W'(1);
  assign instret_d = (retire_i && !(&instret_q)) ? instret_q + CNT_W'(1) : instret_q;

  assign w_halt    = dmem_we_i && (dmem_addr_i == HALT_ADDR);
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (cycle_q == C_TO_LAST);
  // x0 is hardwired zero in the core, so its writes are never mirrored.
  assign w_rf_hit  = rf_we_i && (rf_waddr_i == C_CHK_IDX) && (rf_waddr_i != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RESET;
      rst_cnt_q   <= '0;
      core_rst_q  <= 1'b1;
      cycle_q     <= '0;
      instret_q   <= '0;
      check_q     <= '0;
      halt_data_q <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_RESET: begin
          rst_cnt_q <= rst_cnt_q + RC_W'(1);
          if (rst_cnt_q == C_RST_LAST) begin
            state_q    <= ST_RUN;
            core_rst_q <= 1'b0;
          end
        end
        ST_RUN: begin
          cycle_q   <= cycle_d;
          instret_q <= instret_d;
          if (w_rf_hit) check_q <= rf_wdata_i;
          if (w_halt) begin
            state_q     <= ST_DONE;
            halt_data_q <= dmem_wdata_i;
            done_q      <= 1'b1;
            pass_q      <= (dmem_wdata_i == PASS_VALUE);
          end else if (w_timeout) begin
            state_q   <= ST_TIMEOUT;
            done_q    <= 1'b1;
            pass_q    <= 1'b0;
            timeout_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign core_rst_o      = core_rst_q;
  assign cycle_count_o   = cycle_q;
  assign instret_count_o = instret_q;
  assign check_value_o   = check_q;
  assign halt_data_o     = halt_data_q;
  assign state_o         = state_q;
  assign done_o          = done_q;
  assign pass_o          = pass_q;
  assign timeout_o       = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_core_test_monitor.sv
// ============================================================================
// tb_core_test_monitor: directed self-checking bench for core_test_monitor.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_core_test_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_rst;
  logic        retire, rf_we, dmem_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, dmem_addr, dmem_wdata;
  logic [31:0] cycle_count, instret_count, check_value, halt_data;
  logic [1:0]  state;
  logic        done, pass, timeout;

  int checks = 0;
  int errors = 0;

  core_test_monitor #(
    .XLEN(32), .CNT_W(32), .RESET_CYCLES(4), .TIMEOUT_CYCLES(50), .CHECK_REG(5),
    .HALT_ADDR(32'h0000_0FFC), .PASS_VALUE(32'h1)
  ) dut (
    .clk(clk), .rst(rst), .core_rst_o(core_rst), .retire_i(retire),
    .rf_we_i(rf_we), .rf_waddr_i(rf_waddr), .rf_wdata_i(rf_wdata),
    .dmem_we_i(dmem_we), .dmem_addr_i(dmem_addr), .dmem_wdata_i(dmem_wdata),
    .cycle_count_o(cycle_count), .instret_count_o(instret_count),
    .check_value_o(check_value), .halt_data_o(halt_data), .state_o(state),
    .done_o(done), .pass_o(pass), .timeout_o(timeout)
  );

  initial forever #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    retire = 0; rf_we = 0; rf_waddr = 0; rf_wdata = 0;
    dmem_we = 0; dmem_addr = 0; dmem_wdata = 0;
  endtask

  task automatic start_run();
    idle();
    rst = 1; tick();
    rst = 0; repeat (4) tick();
  endtask

  task automatic test_reset();
    idle();
    rst = 1; repeat (3) tick();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL reset_core_rst: got %b expected 1", core_rst); end
    checks++; if (cycle_count !== 0 || instret_count !== 0) begin errors++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", cycle_count, instret_count); end
    checks++; if ({done, pass, timeout} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {done, pass, timeout}); end
    checks++; if (check_value !== 0 || halt_data !== 0) begin errors++; $display("FAIL reset_data: got %h/%h expected 0/0", check_value, halt_data); end
    rst = 0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++; if (core_rst !== 1'b1 || state !== 2'd0) begin errors++; $display("FAIL stretch_edge%0d: got core_rst=%b state=%0d expected 1/0", k, core_rst, state); end
    end
    tick();
    checks++; if (core_rst !== 1'b0 || state !== 2'd1) begin errors++; $display("FAIL stretch_release: got core_rst=%b state=%0d expected 0/1", core_rst, state); end
    checks++; if (cycle_count !== 0) begin errors++; $display("FAIL run_entry_cycles: got %0d expected 0", cycle_count); end
  endtask

  task automatic test_halt_pass();
    start_run();
    repeat (19) tick();
    dmem_we = 1; dmem_addr = 32'hFFC; dmem_wdata = 32'h1;
    rf_we = 1; rf_waddr = 5; rf_wdata = 32'h33;
    tick();
    idle();
    checks++; if (state !== 2'd2 || done !== 1'b1 || pass !== 1'b1 || timeout !== 1'b0) begin errors++; $display("FAIL halt_pass_flags: got state=%0d d/p/t=%b%b%b expected 2 110", state, done, pass, timeout); end
    checks++; if (halt_data !== 32'h1) begin errors++; $display("FAIL halt_pass_data: got %h expected 00000001", halt_data); end
    checks++; if (cycle_count !== 20) begin errors++; $display("FAIL halt_pass_cycles: got %0d expected 20", cycle_count); end
    checks++; if (check_value !== 32'h33) begin errors++; $display("FAIL halt_same_cycle_rf: got %h expected 00000033", check_value); end
    retire = 1; rf_we = 1; rf_waddr = 5; rf_wdata = 32'h99;
    dmem_we = 1; dmem_addr = 32'hFFC; dmem_wdata = 32'h7;
    repeat (5) tick();
    idle();
    checks++; if (cycle_count !== 20 || instret_count !== 0) begin errors++; $display("FAIL done_frozen_counts: got %0d/%0d expected 20/0", cycle_count, instret_count); end
    checks++; if (halt_data !== 32'h1 || check_value !== 32'h33 || state !== 2'd2 || core_rst !== 1'b0) begin errors++; $display("FAIL done_frozen_data: got %h/%h state=%0d core_rst=%b expected 1/33/2/0", halt_data, check_value, state, core_rst); end
  endtask

  task automatic test_halt_fail();
    start_run();
    dmem_we = 1; dmem_addr = 32'hFF8; dmem_wdata = 32'h2A;
    tick();
    checks++; if (state !== 2'd1 || done !== 1'b0 || halt_data !== 0) begin errors++; $display("FAIL wrong_addr_ignored: got state=%0d done=%b halt=%h expected 1/0/0", state, done, halt_data); end
    dmem_addr = 32'h1000_0FFC;
    tick();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL full_width_addr: got state=%0d expected 1", state); end
    dmem_addr = 32'hFFC;
    tick();
    idle();
    checks++; if (done !== 1'b1 || pass !== 1'b0 || state !== 2'd2) begin errors++; $display("FAIL halt_fail_flags: got d/p=%b%b state=%0d expected 10/2", done, pass, state); end
    checks++; if (halt_data !== 32'h2A || cycle_count !== 3) begin errors++; $display("FAIL halt_fail_data: got %h/%0d expected 2a/3", halt_data, cycle_count); end
  endtask

  task automatic test_timeout();
    start_run();
    repeat (49) tick();
    checks++; if (state !== 2'd1 || timeout !== 1'b0 || cycle_count !== 49) begin errors++; $display("FAIL pre_timeout: got state=%0d to=%b cyc=%0d expected 1/0/49", state, timeout, cycle_count); end
    tick();
    checks++; if (state !== 2'd3 || {done, pass, timeout} !== 3'b101) begin errors++; $display("FAIL timeout_flags: got state=%0d d/p/t=%b%b%b expected 3 101", state, done, pass, timeout); end
    checks++; if (cycle_count !== 50) begin errors++; $display("FAIL timeout_cycles: got %0d expected 50", cycle_count); end
    dmem_we = 1; dmem_addr = 32'hFFC; dmem_wdata = 32'h1;
    repeat (3) tick();
    idle();
    checks++; if (state !== 2'd3 || cycle_count !== 50 || pass !== 1'b0) begin errors++; $display("FAIL timeout_frozen: got state=%0d cyc=%0d pass=%b expected 3/50/0", state, cycle_count, pass); end
  endtask

  task automatic test_timeout_halt_race();
    start_run();
    repeat (49) tick();
    dmem_we = 1; dmem_addr = 32'hFFC; dmem_wdata = 32'h1;
    tick();
    idle();
    checks++; if (state !== 2'd2 || {done, pass, timeout} !== 3'b110) begin errors++; $display("FAIL race_halt_wins: got state=%0d d/p/t=%b%b%b expected 2 110", state, done, pass, timeout); end
    checks++; if (cycle_count !== 50) begin errors++; $display("FAIL race_cycles: got %0d expected 50", cycle_count); end
  endtask

  task automatic test_regfile_instret();
    start_run();
    rf_we = 1; rf_waddr = 5; rf_wdata = 32'h7;
    tick();
    checks++; if (check_value !== 32'h7) begin errors++; $display("FAIL rf_x5_first: got %h expected 00000007", check_value); end
    rf_waddr = 6; rf_wdata = 32'h55;
    tick();
    checks++; if (check_value !== 32'h7) begin errors++; $display("FAIL rf_other_reg: got %h expected 00000007", check_value); end
    rf_waddr = 0; rf_wdata = 32'h9;
    tick();
    checks++; if (check_value !== 32'h7) begin errors++; $display("FAIL rf_x0_ignored: got %h expected 00000007", check_value); end
    rf_waddr = 5; rf_wdata = 32'hAB;
    tick();
    rf_we = 0; rf_wdata = 32'hDEAD;
    tick();
    checks++; if (check_value !== 32'hAB) begin errors++; $display("FAIL rf_x5_last: got %h expected 000000ab", check_value); end
    checks++; if (instret_count !== 0) begin errors++; $display("FAIL instret_idle: got %0d expected 0", instret_count); end
    for (int i = 0; i < 30; i++) begin
      retire = (i % 3 == 0);
      tick();
    end
    idle();
    checks++; if (instret_count !== 10) begin errors++; $display("FAIL instret_count: got %0d expected 10", instret_count); end
    checks++; if (cycle_count !== 35 || state !== 2'd1) begin errors++; $display("FAIL rf_run_cycles: got %0d state=%0d expected 35/1", cycle_count, state); end
  endtask

  task automatic test_mid_run_reset();
    start_run();
    retire = 1; rf_we = 1; rf_waddr = 5; rf_wdata = 32'h44;
    repeat (14) tick();
    checks++; if (cycle_count !== 14 || instret_count !== 14) begin errors++; $display("FAIL mid_pre_counts: got %0d/%0d expected 14/14", cycle_count, instret_count); end
    rst = 1;
    tick();
    checks++; if (state !== 2'd0 || core_rst !== 1'b1) begin errors++; $display("FAIL mid_reset_state: got state=%0d core_rst=%b expected 0/1", state, core_rst); end
    checks++; if (cycle_count !== 0 || instret_count !== 0 || check_value !== 0) begin errors++; $display("FAIL mid_reset_clear: got %0d/%0d/%h expected 0/0/0", cycle_count, instret_count, check_value); end
    rst = 0;
    repeat (3) tick();
    checks++; if (core_rst !== 1'b1 || instret_count !== 0) begin errors++; $display("FAIL mid_restretch: got core_rst=%b instret=%0d expected 1/0", core_rst, instret_count); end
    tick();
    checks++; if (core_rst !== 1'b0 || state !== 2'd1) begin errors++; $display("FAIL mid_rerun: got core_rst=%b state=%0d expected 0/1", core_rst, state); end
    idle();
    repeat (9) tick();
    dmem_we = 1; dmem_addr = 32'hFFC; dmem_wdata = 32'h1;
    tick();
    idle();
    checks++; if (state !== 2'd2 || pass !== 1'b1 || cycle_count !== 10 || instret_count !== 0) begin errors++; $display("FAIL second_run_halt: got state=%0d pass=%b cyc=%0d ir=%0d expected 2/1/10/0", state, pass, cycle_count, instret_count); end
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_halt_pass();
    test_halt_fail();
    test_timeout();
    test_timeout_halt_race();
    test_regfile_instret();
    test_mid_run_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
